// File: rtl/fast_corner_collector.sv
// Collects FAST+NMS corner strobes into a FIFO and frames them per image as
// header / corner words / trailer on a 32-bit valid/ready stream.
module fast_corner_collector #(
  parameter int COORD_WIDTH    = 10,
  parameter int FIFO_DEPTH     = 64,
  parameter int CNT_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   iscorner,
  input  logic [COORD_WIDTH-1:0] x_coord,
  input  logic [COORD_WIDTH-1:0] y_coord,
  input  logic                   frame_end,
  output logic [31:0]            m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   marker_lost
);

  // Stream handshake: a word transfers on a rising edge where m_valid and
  // m_ready are both high; m_valid/m_data/m_last are registers and stay put
  // while m_valid=1 and m_ready=0.

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CAW = $clog2(CNT_FIFO_DEPTH);
  localparam int EW  = 2 * COORD_WIDTH + 2;
  localparam logic [AW:0]  CF_ROOM2 = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [AW:0]  CF_ROOM1 = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [CAW:0] CNT_FULL = (CAW+1)'(CNT_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_TRL} state_t;

  logic [EW-1:0] cf_mem [FIFO_DEPTH];
  logic [AW:0]   cf_wr, cf_rd, cf_used;
  logic [23:0]   cnt_mem [CNT_FIFO_DEPTH];
  logic [CAW:0]  cnt_wr, cnt_rd;
  logic [11:0]   corner_cnt, drop_cnt, corner_next, drop_next;
  logic          corner_in, end_in, end_fits, corner_acc, cf_push;
  logic          cf_empty, cnt_full, cf_pop, cnt_pop, body_adv;
  logic [EW-1:0] cf_entry, head;
  logic [23:0]   cnt_head;
  logic [31:0]   corner_word, trailer_word;
  logic [15:0]   frame_id;
  state_t        state;

  assign cf_used   = cf_wr - cf_rd;
  assign cf_empty  = (cf_used == '0);
  assign cnt_full  = ((cnt_wr - cnt_rd) == CNT_FULL);

  // A lone corner must leave one slot free so the frame's end marker always fits.
  assign corner_in  = ce & iscorner;
  assign end_in     = ce & frame_end;
  assign end_fits   = end_in & (cf_used <= CF_ROOM1) & ~cnt_full;
  assign corner_acc = corner_in & (end_fits | (cf_used <= CF_ROOM2));
  assign cf_push    = end_fits | corner_acc;
  assign cf_entry   = {end_fits, corner_in, y_coord, x_coord};

  assign corner_next = (corner_acc && corner_cnt != 12'hFFF) ? corner_cnt + 12'd1 : corner_cnt;
  assign drop_next   = (corner_in && !corner_acc && drop_cnt != 12'hFFF) ? drop_cnt + 12'd1 : drop_cnt;

  always_ff @(posedge clk) begin
    if (cf_push) cf_mem[cf_wr[AW-1:0]] <= cf_entry;
    if (end_fits) cnt_mem[cnt_wr[CAW-1:0]] <= {drop_next, corner_next};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cf_wr       <= '0;
      cnt_wr      <= '0;
      corner_cnt  <= '0;
      drop_cnt    <= '0;
      marker_lost <= 1'b0;
    end else begin
      if (cf_push) cf_wr <= cf_wr + (AW+1)'(1);
      if (end_fits) begin
        cnt_wr     <= cnt_wr + (CAW+1)'(1);
        corner_cnt <= '0;
        drop_cnt   <= '0;
      end else begin
        corner_cnt <= corner_next;
        drop_cnt   <= drop_next;
      end
      if (end_in && !end_fits) marker_lost <= 1'b1;
    end
  end

  assign head         = cf_mem[cf_rd[AW-1:0]];
  assign cnt_head     = cnt_mem[cnt_rd[CAW-1:0]];
  assign corner_word  = {4'h1, 12'(head[2*COORD_WIDTH-1:COORD_WIDTH]), 4'h0, 12'(head[COORD_WIDTH-1:0])};
  assign trailer_word = {4'hF, cnt_head[23:12], 4'h0, cnt_head[11:0]};

  // Entries leave the FIFO when their word is loaded into the output register.
  assign body_adv = !m_valid || (m_ready && !m_last);

  always_comb begin
    cf_pop  = 1'b0;
    cnt_pop = 1'b0;
    case (state)
      S_HDR, S_BODY: begin
        if (body_adv && !cf_empty) begin
          cf_pop  = 1'b1;
          cnt_pop = !head[EW-2];
        end
      end
      S_TRL:   cnt_pop = m_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cf_rd  <= '0;
      cnt_rd <= '0;
    end else begin
      if (cf_pop)  cf_rd  <= cf_rd + (AW+1)'(1);
      if (cnt_pop) cnt_rd <= cnt_rd + (CAW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      frame_id <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!cf_empty) begin
            m_data  <= {4'hA, 12'h0, frame_id};
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            state   <= S_HDR;
          end
        end
        S_HDR, S_BODY: begin
          if (m_valid && m_last) begin
            if (m_ready) begin
              m_valid  <= 1'b0;
              m_last   <= 1'b0;
              frame_id <= frame_id + 16'd1;
              state    <= S_IDLE;
            end
          end else if (body_adv) begin
            state <= S_BODY;
            if (cf_empty) begin
              m_valid <= 1'b0;
            end else if (head[EW-2]) begin
              m_data  <= corner_word;
              m_valid <= 1'b1;
              m_last  <= 1'b0;
              if (head[EW-1]) state <= S_TRL;
            end else begin
              m_data  <= trailer_word;
              m_valid <= 1'b1;
              m_last  <= 1'b1;
            end
          end
        end
        S_TRL: begin
          // Corner word of a corner-with-end entry is out; trailer follows it.
          if (m_ready) begin
            m_data <= trailer_word;
            m_last <= 1'b1;
            state  <= S_BODY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_corner_collector.sv
// Directed and randomized checks of fast_corner_collector packet framing,
// overflow accounting, back-pressure hold and asynchronous reset.
module tb_fast_corner_collector;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0, iscorner = 1'b0, frame_end = 1'b0, m_ready = 1'b0;
  logic [CW-1:0] x_coord = '0, y_coord = '0;
  logic [31:0]   m_data;
  logic          m_valid, m_last, marker_lost;

  int          checks = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  always #5 clk = ~clk;

  fast_corner_collector #(.COORD_WIDTH(CW), .FIFO_DEPTH(64), .CNT_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .iscorner(iscorner), .x_coord(x_coord),
    .y_coord(y_coord), .frame_end(frame_end), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .marker_lost(marker_lost)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] hw(input logic [15:0] fid);
    return {1'b0, 4'hA, 12'h0, fid};
  endfunction

  function automatic logic [32:0] cw(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return {1'b0, 4'h1, 12'(y), 4'h0, 12'(x)};
  endfunction

  function automatic logic [32:0] tw(input logic [11:0] drop, input logic [11:0] cnt);
    return {1'b1, 4'hF, drop, 4'h0, cnt};
  endfunction

  // Scoreboard: every transferred word must be the next expected one.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL extra_word observed=%h expected=none", {m_last, m_data});
      end else begin
        mon_e = exp_q.pop_front();
        check("stream_word", {31'h0, m_last, m_data}, {31'h0, mon_e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic ic, input logic [CW-1:0] x, input logic [CW-1:0] y, input logic fe);
    ce = 1'b1; iscorner = ic; x_coord = x; y_coord = y; frame_end = fe;
    tick();
    ce = 1'b0; iscorner = 1'b0; frame_end = 1'b0;
  endtask

  task automatic drain(input int budget, input bit rnd, input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && !m_valid) && n < budget) begin
      m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    m_ready = 1'b1;
    check({"drain_left_", tag}, 64'(exp_q.size()), 64'd0);
    check({"drain_idle_", tag}, 64'(m_valid), 64'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b0; ce = 1'b0; iscorner = 1'b0; frame_end = 1'b0; m_ready = 1'b0;
    exp_q.delete();
    #1;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_lost", 64'(marker_lost), 64'd0);
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int nc;
    logic ce_v, ic_v;
    logic [CW-1:0] xr, yr;
    #2;

    // Three corners then a lone frame end.
    reset_dut();
    m_ready = 1'b1;
    exp_q.push_back(hw(0)); exp_q.push_back(cw(3, 5)); exp_q.push_back(cw(7, 5));
    exp_q.push_back(cw(1, 9)); exp_q.push_back(tw(0, 3));
    pix(1, 3, 5, 0); pix(1, 7, 5, 0); pix(1, 1, 9, 0); pix(0, 0, 0, 1);
    drain(200, 0, "t1");

    // Corner coinciding with frame end, then an empty frame.
    reset_dut();
    m_ready = 1'b1;
    exp_q.push_back(hw(0)); exp_q.push_back(cw(2, 4)); exp_q.push_back(tw(0, 1));
    pix(1, 2, 4, 1);
    drain(200, 0, "t2a");
    exp_q.push_back(hw(1)); exp_q.push_back(tw(0, 0));
    pix(0, 0, 0, 1);
    drain(200, 0, "t2b");

    // Two empty frames back to back.
    reset_dut();
    m_ready = 1'b1;
    exp_q.push_back(hw(0)); exp_q.push_back(tw(0, 0));
    exp_q.push_back(hw(1)); exp_q.push_back(tw(0, 0));
    pix(0, 0, 0, 1); pix(0, 0, 0, 1);
    drain(200, 0, "t3");

    // Overflow: 70 corners into a 64-entry FIFO with the sink stalled.
    reset_dut();
    for (int i = 0; i < 70; i++) pix(1, CW'(i), CW'(i + 100), 0);
    pix(0, 0, 0, 1);
    repeat (3) tick();
    check("t4_hdr_valid", 64'(m_valid), 64'd1);
    check("t4_hdr_hold", 64'(m_data), 64'h0000_0000_A000_0000);
    check("t4_lost", 64'(marker_lost), 64'd0);
    exp_q.push_back(hw(0));
    for (int i = 0; i < 63; i++) exp_q.push_back(cw(CW'(i), CW'(i + 100)));
    exp_q.push_back(33'h1_F007_003F);
    m_ready = 1'b1;
    repeat (10) tick();
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_stall_valid", 64'(m_valid), 64'd1);
      check("t4_stall_data", 64'(m_data), 64'(exp_q[0][31:0]));
      check("t4_stall_last", 64'(m_last), 64'(exp_q[0][32]));
    end
    drain(300, 0, "t4");

    // Count FIFO overflow loses the fifth frame end.
    reset_dut();
    for (int k = 0; k < 4; k++) pix(0, 0, 0, 1);
    check("t5_lost_before", 64'(marker_lost), 64'd0);
    pix(0, 0, 0, 1);
    check("t5_lost_after", 64'(marker_lost), 64'd1);
    for (int k = 0; k < 5; k++) pix(1, CW'(k + 10), CW'(k + 20), 0);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(hw(16'(k)));
      exp_q.push_back(tw(0, 0));
    end
    exp_q.push_back(hw(4));
    for (int k = 0; k < 5; k++) exp_q.push_back(cw(CW'(k + 10), CW'(k + 20)));
    exp_q.push_back(tw(0, 5));
    m_ready = 1'b1;
    repeat (20) tick();
    check("t5_lost_sticky", 64'(marker_lost), 64'd1);
    pix(0, 0, 0, 1);
    drain(200, 0, "t5");

    // Asynchronous reset after the second corner word.
    reset_dut();
    for (int k = 0; k < 4; k++) pix(1, CW'(k + 1), CW'(k + 2), 0);
    repeat (2) tick();
    exp_q.push_back(hw(0)); exp_q.push_back(cw(1, 2)); exp_q.push_back(cw(2, 3));
    m_ready = 1'b1;
    repeat (3) tick();
    m_ready = 1'b0;
    check("t6_pre_left", 64'(exp_q.size()), 64'd0);
    check("t6_pre_valid", 64'(m_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("t6_async_valid", 64'(m_valid), 64'd0);
    check("t6_async_data", 64'(m_data), 64'd0);
    check("t6_async_last", 64'(m_last), 64'd0);
    tick();
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (5) tick();
    check("t6_no_stale", 64'(m_valid), 64'd0);
    exp_q.push_back(hw(0)); exp_q.push_back(cw(9, 9)); exp_q.push_back(tw(0, 1));
    pix(1, 9, 9, 1);
    drain(200, 0, "t6");

    // Randomized frames with ce gating and random back-pressure.
    reset_dut();
    for (int f = 0; f < 12; f++) begin
      exp_q.push_back(hw(16'(f)));
      nc = 0;
      for (int c = 0; c < int'($urandom_range(0, 30)); c++) begin
        ce_v = ($urandom_range(0, 3) != 0);
        ic_v = 1'($urandom_range(0, 1));
        xr = CW'($urandom); yr = CW'($urandom);
        ce = ce_v; iscorner = ic_v; x_coord = xr; y_coord = yr;
        frame_end = ce_v ? 1'b0 : 1'($urandom_range(0, 1));
        m_ready = ($urandom_range(0, 3) != 0);
        if (ce_v && ic_v) begin
          exp_q.push_back(cw(xr, yr));
          nc++;
        end
        tick();
      end
      ic_v = 1'($urandom_range(0, 1));
      xr = CW'($urandom); yr = CW'($urandom);
      if (ic_v) begin
        exp_q.push_back(cw(xr, yr));
        nc++;
      end
      exp_q.push_back(tw(0, 12'(nc)));
      pix(ic_v, xr, yr, 1);
      drain(2000, 1, "rnd");
    end
    check("rnd_lost", 64'(marker_lost), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fast_corner_collector.md
Name: fast_corner_collector

Overview:
- Receiving end of the FAST+NMS corner stream. Samples the per-pixel corner strobe (iscorner, x_coord, y_coord) under ce and buffers accepted corners in an on-chip FIFO.
- Emits one framed packet per image on a 32-bit valid/ready stream: a header word, one word per corner, and a trailer word carrying per-frame counts.
- Sits between the feature pipeline and the DMA/host writer. The pipeline side never stalls; overflow is counted, not back-pressured.

Parameters:
- COORD_WIDTH, 10, width of x_coord/y_coord; legal range 1..12.
- FIFO_DEPTH, 64, corner FIFO entries; power of two, ≥4.
- CNT_FIFO_DEPTH, 4, frame-count FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  input-side qualifier; iscorner and frame_end are sampled only when ce=1.
- iscorner  in  1  current coordinate is a corner.
- x_coord  in  COORD_WIDTH  column of the corner.
- y_coord  in  COORD_WIDTH  row of the corner.
- frame_end  in  1  single-cycle pulse marking the last pixel of a frame; may coincide with iscorner.
- m_data  out  32  packet word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts.
- m_last  out  1  current word is the trailer.
- marker_lost  out  1  sticky; a frame_end was discarded.

Behaviour:
- Reset (rst=0, asynchronous): m_valid=0, m_last=0, m_data=0, marker_lost=0, frame_id=0. Both FIFOs are emptied, both per-frame counters are cleared, and the FSM goes to S_IDLE. This takes effect immediately, including mid-packet; the partial packet is abandoned.
- Corner FIFO entry is {end, has_corner, y, x}:
  - Corner only: has_corner=1, end=0.
  - Corner with end (iscorner and frame_end in the same cycle): has_corner=1, end=1. One entry.
  - End only: has_corner=0, end=1.
- Write rules, for a ce cycle:
  - end=0 entry: written only if free slots ≥2. Otherwise the corner is dropped and drop_cnt increments.
  - end=1 entry: needs free ≥1 in the corner FIFO and a free slot in the count FIFO.
    - If it fits: push {drop_cnt, corner_cnt}, including this cycle's corner, into the count FIFO, then clear both counters.
    - If it does not fit: frame_end is ignored, counters keep accumulating into the next frame, and marker_lost is set. If a corner was present it is then treated as an end=0 write.
  - corner_cnt and drop_cnt are 12-bit, saturating at 4095.
- Write latency: an entry is visible at the FIFO head one clock after its ce cycle.
- Output words:
  - Header: [31:28]=4'hA, [27:16]=0, [15:0]=frame_id.
  - Corner: [31:28]=4'h1, [27:16]=y zero-extended, [15:12]=0, [11:0]=x zero-extended.
  - Trailer: [31:28]=4'hF, [27:16]=drop count, [15:12]=0, [11:0]=corner count; m_last=1.
- FSM (all outputs registered; m_valid never depends combinationally on m_ready):
  - S_IDLE: m_valid=0. When the corner FIFO is non-empty, load the header and go to S_HDR. The header is valid 2 clocks after the first entry's ce cycle.
  - S_HDR: hold the header until m_ready; then go to S_BODY.
  - S_BODY, head entry has_corner=1: present the corner word; on handshake, pop.
    - If end=1, go to S_TRL.
  - S_BODY, head entry end-only: present the trailer; on handshake, pop, pop the count FIFO, increment frame_id (wraps at 65535→0), go to S_IDLE.
  - S_TRL: present the trailer from the count-FIFO head; on handshake, pop the count FIFO, increment frame_id, go to S_IDLE.
  - S_BODY with the FIFO empty: m_valid=0 and wait. A packet may span arbitrarily long gaps.
- While m_valid=1 and m_ready=0: m_data and m_last are held stable.
- Back-to-back handshakes sustain 1 word/clock. Push and pop in the same cycle on a full-minus-one FIFO are legal.
- Output side ignores ce.

Test Plan:
- Frame with corners (3,5), (7,5), (1,9); frame_end alone afterwards; m_ready=1 → A0000000, 10050003, 10050007, 10090001, F0000003 (last=1).
- Corner (2,4) with frame_end in the same cycle; m_ready=1 → A0000000, 10040002, F0000001 (last=1); a second frame then uses header A0000001.
- frame_end with no corners, twice → two packets: A0000000, F0000000 and A0000001, F0000000.
- FIFO_DEPTH=64, m_ready=0, 70 corners then frame_end → 63 stored. After releasing m_ready: 63 corner words, trailer F007003F. Then hold m_ready=0 for 3 cycles mid-packet and check m_data stays stable.
- m_ready=0, 5 consecutive end-only frames with CNT_FIFO_DEPTH=4 → marker_lost=1. Five corners added to the next frame then show trailer count 5; frame_ids 0..4 are emitted in order.
- Assert rst=0 mid-packet after the 2nd corner word → m_valid drops immediately. Next frame starts with header A0000000 and the FIFO holds no stale entries.
